// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the access-legality check used when a request is accepted.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE,
      RMW_RD,
      RMW_WR,
      RESP
   } lsuState;

   // Misaligned halfword/word, reserved funct3, or an unsigned-only code used for a store.
   function automatic logic accessErr(input logic isWrite, input logic [2:0] funct3,
                                      input logic [1:0] byteOff);
      logic err;
      case (funct3)
         F3_B:    err = 1'b0;
         F3_H:    err = byteOff[0];
         F3_W:    err = (byteOff != 2'b00);
         F3_BU:   err = isWrite;
         F3_HU:   err = isWrite | byteOff[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load lane from a RAM word,
// and merges a byte/halfword store lane into a previously read word.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int dataW = 32
) (
   input  logic [2:0]       funct3,
   input  logic [1:0]       byteOff,
   input  logic [dataW-1:0] rdWord,
   input  logic [dataW-1:0] baseWord,
   input  logic [dataW-1:0] wrData,
   output logic [dataW-1:0] loadData,
   output logic [dataW-1:0] mergeData
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   always_comb begin
      byteLane = rdWord[{byteOff, 3'b000} +: 8];
      halfLane = rdWord[{byteOff[1], 4'b0000} +: 16];

      loadData = rdWord;
      case (funct3)
         F3_B:    loadData = {{(dataW-8){byteLane[7]}}, byteLane};
         F3_H:    loadData = {{(dataW-16){halfLane[15]}}, halfLane};
         F3_BU:   loadData = {{(dataW-8){1'b0}}, byteLane};
         F3_HU:   loadData = {{(dataW-16){1'b0}}, halfLane};
         default: loadData = rdWord;
      endcase

      mergeData = baseWord;
      case (funct3[1:0])
         2'b00:   mergeData[{byteOff, 3'b000} +: 8]      = wrData[7:0];
         2'b01:   mergeData[{byteOff[1], 4'b0000} +: 16] = wrData[15:0];
         default: mergeData = baseWord;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a single-port, zero-delay-read RAM.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int dataW       = 32,
   parameter int RAMAddrSize = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [2:0]             req_funct3,
   input  logic [31:0]            req_addr,
   input  logic [dataW-1:0]       req_wdata,
   output logic                   resp_valid,
   output logic [dataW-1:0]       resp_rdata,
   output logic                   resp_err,
   output logic [RAMAddrSize-1:0] ram_addr,
   output logic [dataW-1:0]       ram_wdata,
   output logic                   ram_we,
   input  logic [dataW-1:0]       ram_rdata
);

   lsuState                state, nextState;
   logic [2:0]             funct3Reg;
   logic [RAMAddrSize-1:0] addrReg;
   logic [dataW-1:0]       wdataReg;
   logic [dataW-1:0]       capWord;
   logic [dataW-1:0]       rdataReg;
   logic                   errReg;
   logic                   handshake;
   logic                   reqErr;
   logic [dataW-1:0]       loadData;
   logic [dataW-1:0]       mergeData;
   logic                   unusedAddrBits;

   // Address bits beyond the RAM size wrap and are deliberately dropped.
   assign unusedAddrBits = ^req_addr[31:RAMAddrSize];

   assign handshake = req_valid & (state == IDLE);
   assign reqErr    = accessErr(req_write, req_funct3, req_addr[1:0]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (reqErr)                  nextState = RESP;
               else if (!req_write)         nextState = LOAD;
               else if (req_funct3 == F3_W) nextState = STORE;
               else                         nextState = RMW_RD;
            end
         end
         LOAD:    nextState = RESP;
         STORE:   nextState = RESP;
         RMW_RD:  nextState = RMW_WR;
         RMW_WR:  nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      resp_err   = (state == RESP) & errReg;
      ram_we     = (state == STORE) | (state == RMW_WR);
      ram_wdata  = '0;
      if (state == STORE)  ram_wdata = wdataReg;
      if (state == RMW_WR) ram_wdata = mergeData;
   end

   assign ram_addr   = {addrReg[RAMAddrSize-1:2], 2'b00};
   assign resp_rdata = rdataReg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         funct3Reg <= '0;
         addrReg   <= '0;
         wdataReg  <= '0;
         capWord   <= '0;
         rdataReg  <= '0;
         errReg    <= 1'b0;
      end else begin
         if (handshake) begin
            funct3Reg <= req_funct3;
            addrReg   <= req_addr[RAMAddrSize-1:0];
            wdataReg  <= req_wdata;
            errReg    <= reqErr;
            rdataReg  <= '0;
         end
         if (state == LOAD)   rdataReg <= loadData;
         if (state == RMW_RD) capWord  <= ram_rdata;
      end
   end

   lsu_align #(
      .dataW(dataW)
   ) uAlign (
      .funct3   (funct3Reg),
      .byteOff  (addrReg[1:0]),
      .rdWord   (ram_rdata),
      .baseWord (capWord),
      .wrData   (wdataReg),
      .loadData (loadData),
      .mergeData(mergeData)
   );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// backpressure sequences, then random traffic against a byte-array memory model.
module tb_load_store_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [31:0] ram_rdata;

   int nChecks = 0;
   int nFails  = 0;

   // zeroDelayRAM
   logic [31:0] mem [64];
   assign ram_rdata = mem[ram_addr[7:2]];
   always @(posedge clock) if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;

   logic [7:0] refMem [256];

   always #5 clock = ~clock;

   load_store_unit #(
      .dataW(32),
      .RAMAddrSize(8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata)
   );

   typedef struct {
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] expD;
      bit          expE;
      int          expL;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // One full transaction: handshake, wait for the response, check it.
   task automatic doReq(input string nm, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] expD, input bit expE, input int expL);
      int cnt;
      int weCnt;
      bit got;
      @(negedge clock);
      cnt = 0;
      while (!req_ready && cnt < 20) begin
         @(negedge clock);
         cnt++;
      end
      check({nm, " ready"}, 32'(req_ready), 32'd1);
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      cnt   = 1;
      weCnt = 0;
      got   = 1'b0;
      while (cnt <= 8) begin
         if (ram_we) weCnt++;
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         @(negedge clock);
         cnt++;
      end
      check({nm, " respSeen"}, 32'(got), 32'd1);
      check({nm, " latency"}, 32'(cnt), 32'(expL));
      check({nm, " rdata"}, resp_rdata, expD);
      check({nm, " err"}, 32'(resp_err), 32'(expE));
      check({nm, " weCycles"}, 32'(weCnt), (w && !expE) ? 32'd1 : 32'd0);
      @(negedge clock);
      check({nm, " pulse"}, 32'(resp_valid), 32'd0);
   endtask

   // Reference behaviour from the ISA rules on a flat byte memory.
   task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] expD,
                        output bit expE, output int expL);
      int sz;
      int base;
      logic [31:0] v;
      sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      base = int'(a[7:0]);
      expE = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) ||
             ((int'(a[1:0]) % sz) != 0);
      expD = '0;
      if (expE) expL = 1;
      else if (w) begin
         for (int i = 0; i < sz; i++) refMem[base+i] = 8'(wd >> (8*i));
         expL = (sz == 4) ? 2 : 3;
      end else begin
         v = '0;
         for (int i = 0; i < sz; i++) v = v | (32'(refMem[base+i]) << (8*i));
         if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
         expD = v;
         expL = 2;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] eD;
      bit          eE;
      int          eL;
      int          hs;
      int          rsp;
      int          rspAt;
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;

      #12;
      check("rst ready", 32'(req_ready), 32'd1);
      check("rst respValid", 32'(resp_valid), 32'd0);
      check("rst respErr", 32'(resp_err), 32'd0);
      check("rst ramWe", 32'(ram_we), 32'd0);
      check("rst rdata", resp_rdata, 32'd0);
      check("rst ramAddr", 32'(ram_addr), 32'd0);
      check("rst ramWdata", ram_wdata, 32'd0);
      #11 reset = 1'b1;

      //                  w  f3      addr        wdata         expD          err  lat
      tbl.push_back('{1'b1, 3'b010, 32'h40,  32'hDEADBEEF, 32'h0,        1'b0, 2});
      tbl.push_back('{1'b0, 3'b010, 32'h40,  32'h0,        32'hDEADBEEF, 1'b0, 2});
      tbl.push_back('{1'b1, 3'b010, 32'h40,  32'h11223344, 32'h0,        1'b0, 2});
      tbl.push_back('{1'b1, 3'b000, 32'h41,  32'h5A,       32'h0,        1'b0, 3});
      tbl.push_back('{1'b0, 3'b010, 32'h40,  32'h0,        32'h11225A44, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b000, 32'h41,  32'h0,        32'h0000005A, 1'b0, 2});
      tbl.push_back('{1'b1, 3'b010, 32'h40,  32'h0000F080, 32'h0,        1'b0, 2});
      tbl.push_back('{1'b0, 3'b000, 32'h40,  32'h0,        32'hFFFFFF80, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b100, 32'h40,  32'h0,        32'h00000080, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b001, 32'h40,  32'h0,        32'hFFFFF080, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b101, 32'h40,  32'h0,        32'h0000F080, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b010, 32'h42,  32'h0,        32'h0,        1'b1, 1});
      tbl.push_back('{1'b1, 3'b001, 32'h43,  32'hBEEF,     32'h0,        1'b1, 1});
      tbl.push_back('{1'b0, 3'b010, 32'h40,  32'h0,        32'h0000F080, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b001, 32'h42,  32'h0,        32'h0,        1'b0, 2});
      tbl.push_back('{1'b0, 3'b011, 32'h40,  32'h0,        32'h0,        1'b1, 1});
      tbl.push_back('{1'b1, 3'b100, 32'h40,  32'h12,       32'h0,        1'b1, 1});
      tbl.push_back('{1'b1, 3'b001, 32'h42,  32'hABCD,     32'h0,        1'b0, 3});
      tbl.push_back('{1'b0, 3'b010, 32'h40,  32'h0,        32'hABCDF080, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b001, 32'h42,  32'h0,        32'hFFFFABCD, 1'b0, 2});
      tbl.push_back('{1'b0, 3'b100, 32'h143, 32'h0,        32'h000000AB, 1'b0, 2});
      tbl.push_back('{1'b1, 3'b000, 32'h140, 32'h12345699, 32'h0,        1'b0, 3});
      tbl.push_back('{1'b0, 3'b010, 32'h40,  32'h0,        32'hABCDF099, 1'b0, 2});

      foreach (tbl[i])
         doReq($sformatf("vec%0d", i), tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd,
               tbl[i].expD, tbl[i].expE, tbl[i].expL);

      // Reset in the middle of the write phase of SH 0xBEEF to 0x44.
      doReq("pre44", 1'b1, 3'b010, 32'h44, 32'h12345678, 32'h0, 1'b0, 2);
      req_write  = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 32'h44;
      req_wdata  = 32'hBEEF;
      req_valid  = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rmwWr we", 32'(ram_we), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("asyncRst we", 32'(ram_we), 32'd0);
      check("asyncRst ramWdata", ram_wdata, 32'd0);
      check("asyncRst ramAddr", 32'(ram_addr), 32'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      rsp = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (resp_valid) rsp++;
      end
      check("asyncRst noResp", 32'(rsp), 32'd0);
      check("asyncRst ready", 32'(req_ready), 32'd1);
      doReq("post44", 1'b0, 3'b010, 32'h44, 32'h0, 32'h12345678, 1'b0, 2);

      // req_valid held through a busy SB.
      doReq("pre48", 1'b1, 3'b010, 32'h48, 32'hA0B0C0D0, 32'h0, 1'b0, 2);
      @(negedge clock);
      req_write  = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h49;
      req_wdata  = 32'h77;
      req_valid  = 1'b1;
      hs = 0;
      rsp = 0;
      rspAt = -1;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid) begin
            rsp++;
            if (rspAt < 0) rspAt = i;
            req_valid = 1'b0;
         end else if (req_valid && req_ready) hs++;
         @(negedge clock);
      end
      req_valid = 1'b0;
      check("busy handshakes", 32'(hs), 32'd1);
      check("busy responses", 32'(rsp), 32'd1);
      check("busy latency", 32'(rspAt), 32'd3);
      doReq("post48", 1'b0, 3'b010, 32'h48, 32'h0, 32'hA0B077D0, 1'b0, 2);

      // Random traffic against the byte-array model; fill every word first.
      for (int k = 0; k < 64; k++) begin
         wd = $urandom;
         model(1'b1, 3'b010, 32'(k*4), wd, eD, eE, eL);
         doReq($sformatf("fill%0d", k), 1'b1, 3'b010, 32'(k*4), wd, eD, eE, eL);
      end
      for (int n = 0; n < 300; n++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom)};
         wd = $urandom;
         model(w, f3, a, wd, eD, eE, eL);
         doReq($sformatf("rnd%0d", n), w, f3, a, wd, eD, eE, eL);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
